// File: rtl/serdesphy_cdr_loop_filter.sv
// serdesphy_cdr_loop_filter: bang-bang PD votes to 8-bit CDR VCO control via PI filter with lock FSM
module serdesphy_cdr_loop_filter #(
  parameter int INT_W       = 16,
  parameter int KP          = 4,
  parameter int KI_SHIFT    = 6,
  parameter int LOCK_WIN    = 64,
  parameter int LOCK_THRESH = 4,
  parameter int LOCK_COUNT  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       vco_ready,
  input  logic       freeze,
  input  logic       pd_valid,
  input  logic       pd_early,
  input  logic       pd_late,
  output logic [7:0] cdr_control,
  output logic       cdr_locked,
  output logic [1:0] loop_state
);
  localparam int WW = $clog2(LOCK_WIN + 1);
  localparam int NW = WW + 1;
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int CW = INT_W + 8;
  localparam logic signed [INT_W:0] IMAX = (INT_W+1)'(2**(INT_W-1) - 1);
  localparam logic signed [INT_W:0] IMIN = -IMAX;
  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED, HOLD} state_t;
  state_t state;
  logic signed [INT_W-1:0] integ, integ_nx;
  logic signed [INT_W:0] integ_sum;
  logic signed [1:0] v;
  logic signed [CW-1:0] i_term, p_term, ctl_sum;
  logic [7:0] ctl_nx;
  logic [WW-1:0] wcnt;
  logic signed [NW-1:0] net, net_nx;
  logic [NW-1:0] abs_net;
  logic [GW-1:0] gcnt;
  logic win_last, win_good, win_bad;
  always_comb begin
    v = (pd_valid & pd_early & ~pd_late) ? 2'sd1 : (pd_valid & pd_late & ~pd_early) ? -2'sd1 : 2'sd0;
    integ_sum = {integ[INT_W-1], integ} + (INT_W+1)'(v);
    integ_nx = integ_sum > IMAX ? IMAX[INT_W-1:0] : integ_sum < IMIN ? IMIN[INT_W-1:0] : integ_sum[INT_W-1:0];
    i_term = CW'(integ_nx >>> KI_SHIFT);
    p_term = v == 2'sd1 ? CW'(state == ACQUIRE ? 2*KP : KP) : v == -2'sd1 ? -CW'(state == ACQUIRE ? 2*KP : KP) : '0;
    ctl_sum = CW'(128) + i_term + p_term;
    ctl_nx = ctl_sum[CW-1] ? 8'd0 : |ctl_sum[CW-2:8] ? 8'd255 : ctl_sum[7:0];
    net_nx = net + NW'(v);
    abs_net = net_nx[NW-1] ? NW'(-net_nx) : NW'(net_nx);
    win_last = pd_valid && wcnt == WW'(LOCK_WIN - 1);
    win_good = abs_net <= NW'(LOCK_THRESH);
    win_bad = abs_net > NW'(2*LOCK_THRESH);
  end
  assign loop_state = state;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || !enable || !vco_ready) begin
      state       <= IDLE;
      integ       <= '0;
      cdr_control <= 8'd128;
      cdr_locked  <= 1'b0;
      wcnt        <= '0;
      net         <= '0;
      gcnt        <= '0;
    end else begin
      case (state)
        IDLE: state <= ACQUIRE;
        HOLD: state <= freeze ? HOLD : LOCKED;
        default: begin
          // freeze takes priority over everything in LOCKED, including a window close
          if (state == LOCKED && freeze) state <= HOLD;
          else begin
            integ       <= integ_nx;
            cdr_control <= ctl_nx;
            if (win_last) begin
              wcnt <= '0;
              net  <= '0;
              if (state == ACQUIRE) begin
                gcnt <= win_good ? gcnt + GW'(1) : '0;
                if (win_good && gcnt == GW'(LOCK_COUNT - 1)) begin
                  state      <= LOCKED;
                  cdr_locked <= 1'b1;
                end
              end else if (win_bad) begin
                state      <= ACQUIRE;
                cdr_locked <= 1'b0;
                gcnt       <= '0;
              end
            end else if (pd_valid) begin
              wcnt <= wcnt + WW'(1);
              net  <= net_nx;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serdesphy_cdr_loop_filter.sv
// tb_serdesphy_cdr_loop_filter: directed checks of PI output, saturation, lock FSM, freeze and idle recovery
module tb_serdesphy_cdr_loop_filter;
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b1, vco_ready = 1'b1, freeze = 1'b0;
  logic pd_valid = 1'b0, pd_early = 1'b0, pd_late = 1'b0;
  logic [7:0] cdr_control;
  logic cdr_locked;
  logic [1:0] loop_state;
  int n_chk = 0, n_fail = 0;
  serdesphy_cdr_loop_filter dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .vco_ready(vco_ready), .freeze(freeze),
    .pd_valid(pd_valid), .pd_early(pd_early), .pd_late(pd_late),
    .cdr_control(cdr_control), .cdr_locked(cdr_locked), .loop_state(loop_state)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step(input logic e, input logic l);
    pd_valid = e | l;
    pd_early = e;
    pd_late  = l;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    step(0, 0);
  endtask
  task automatic lock_up();
    do_reset();
    for (int i = 0; i < 256; i++) step(i % 2 == 0, i % 2 == 1);
  endtask
  initial begin
    int mn;
    #12;
    chk("rst_ctl", cdr_control, 128);
    chk("rst_lock", cdr_locked, 0);
    chk("rst_state", loop_state, 0);
    rst_n = 1'b1;
    step(0, 0);
    chk("post_rst_state", loop_state, 1);
    step(1, 0);
    chk("acq_early1", cdr_control, 136);
    for (int i = 0; i < 63; i++) step(1, 0);
    chk("acq_early64", cdr_control, 137);
    rst_n = 1'b0;
    #1;
    chk("async_rst_ctl", cdr_control, 128);
    chk("async_rst_state", loop_state, 0);
    #2;
    rst_n = 1'b1;
    step(0, 0);
    step(0, 1);
    chk("acq_late1", cdr_control, 119);
    do_reset();
    for (int i = 0; i < 7615; i++) step(1, 0);
    chk("clamp_below", cdr_control, 254);
    step(1, 0);
    chk("clamp_at", cdr_control, 255);
    mn = 255;
    for (int i = 0; i < 25400; i++) begin
      step(1, 0);
      if (cdr_control < mn) mn = cdr_control;
    end
    chk("sat_hold", mn, 255);
    step(0, 1);
    chk("sat_no_wrap", cdr_control, 255);
    chk("sat_state", loop_state, 1);
    do_reset();
    for (int i = 0; i < 256; i++) begin
      step(i % 2 == 0, i % 2 == 1);
      chk("alt_ctl", cdr_control, i % 2 == 0 ? 136 : 120);
      if (i == 254) begin
        chk("pre_lock_state", loop_state, 1);
        chk("pre_lock_flag", cdr_locked, 0);
      end
    end
    chk("lock_state", loop_state, 2);
    chk("lock_flag", cdr_locked, 1);
    for (int i = 0; i < 63; i++) step(1, 0);
    chk("locked_mid_state", loop_state, 2);
    step(1, 0);
    chk("unlock_state", loop_state, 1);
    chk("unlock_flag", cdr_locked, 0);
    chk("unlock_ctl", cdr_control, 133);
    lock_up();
    step(1, 0);
    chk("locked_early", cdr_control, 132);
    step(0, 1);
    chk("locked_late", cdr_control, 124);
    for (int i = 0; i < 30; i++) step(1, 0);
    chk("pre_freeze_ctl", cdr_control, 132);
    freeze = 1'b1;
    mn = 0;
    for (int i = 0; i < 100; i++) begin
      step(1, 0);
      if (loop_state != 3 || cdr_control != 132 || !cdr_locked) mn++;
    end
    chk("hold_steady", mn, 0);
    chk("hold_state", loop_state, 3);
    freeze = 1'b0;
    step(0, 0);
    chk("release_state", loop_state, 2);
    for (int i = 0; i < 31; i++) step(1, 0);
    chk("resume_mid_state", loop_state, 2);
    step(1, 0);
    chk("resume_close_state", loop_state, 1);
    chk("resume_close_ctl", cdr_control, 132);
    lock_up();
    for (int i = 0; i < 10; i++) step(1, 0);
    vco_ready = 1'b0;
    step(1, 0);
    chk("vco_drop_ctl", cdr_control, 128);
    chk("vco_drop_lock", cdr_locked, 0);
    chk("vco_drop_state", loop_state, 0);
    vco_ready = 1'b1;
    step(0, 0);
    chk("recover_state", loop_state, 1);
    for (int i = 0; i < 255; i++) step(i % 2 == 0, i % 2 == 1);
    chk("relock_pending", loop_state, 1);
    step(0, 1);
    chk("relock_state", loop_state, 2);
    chk("relock_flag", cdr_locked, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/serdesphy_cdr_loop_filter.md
Name: serdesphy_cdr_loop_filter

Overview:
Digital CDR loop filter. It converts bang-bang phase-detector early/late votes into the 8-bit cdr_control word that steers the RX CDR VCO (code 128 = 240 MHz centre, 0.1 MHz/LSB).
- Proportional-plus-integral (PI) path.
- Acquire/lock state machine with a windowed lock detector.
- Freeze (hold) mode.
It sits between the RX phase detector and the CDR VCO, in the recovered-data clock domain.

Parameters:
- INT_W, 16: integrator width in bits, signed.
- KP, 4: proportional step in LSBs while LOCKED. ACQUIRE uses 2*KP.
- KI_SHIFT, 6: integrator gain; the integral term is the integrator arithmetic-shifted right by KI_SHIFT.
- LOCK_WIN, 64: number of valid PD samples per lock-detect window.
- LOCK_THRESH, 4: a window is good when |net votes| <= LOCK_THRESH.
- LOCK_COUNT, 4: consecutive good windows needed to declare lock.

Ports:
- clk  input  1  CDR-domain clock.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  loop enable.
- vco_ready  input  1  CDR VCO stable flag.
- freeze  input  1  hold the loop state (honoured in LOCKED only).
- pd_valid  input  1  PD sample strobe.
- pd_early  input  1  data edge early: raise frequency.
- pd_late  input  1  data edge late: lower frequency.
- cdr_control  output  8  VCO control word.
- cdr_locked  output  1  lock indication.
- loop_state  output  2  0=IDLE, 1=ACQUIRE, 2=LOCKED, 3=HOLD.

Behaviour:
- Reset values (async, active-low): loop_state=IDLE, cdr_control=8'd128, cdr_locked=0. Integrator, window counter, net-vote accumulator and good-window counter all clear to 0.
- Vote: v = +1 if pd_valid & pd_early & !pd_late; v = -1 if pd_valid & pd_late & !pd_early; otherwise v = 0 (both set or neither set counts as 0).
- Integrator: integ_next = integ + v. Saturate at +(2^(INT_W-1)-1) and -(2^(INT_W-1)-1); no wrap.
- Output: registered, one edge of latency after the vote is sampled.
  - cdr_control <= clamp(128 + (integ_next >>> KI_SHIFT) + G*v, 0, 255).
  - G = 2*KP in ACQUIRE, KP in LOCKED.
  - Use a signed intermediate of at least INT_W+2 bits.
  - The shift is arithmetic: -1 >>> 6 = -1.
- IDLE:
  - Entered whenever enable=0 or vco_ready=0, from any state, taking effect at the next edge.
  - Forces integ=0, cdr_control=128, cdr_locked=0, and clears all counters.
  - Leaves to ACQUIRE at the first edge where enable=1 and vco_ready=1.
- Lock detector (ACQUIRE and LOCKED only):
  - wcnt counts valid samples; net accumulates v.
  - When wcnt reaches LOCK_WIN on a sample, that window closes: evaluate the window including that sample, then clear wcnt and net.
- ACQUIRE:
  - Good window: gcnt++. Bad window: gcnt=0.
  - When gcnt reaches LOCK_COUNT, go to LOCKED and set cdr_locked=1 at that same edge.
- LOCKED:
  - Closing a window with |net| > 2*LOCK_THRESH: go to ACQUIRE, cdr_locked=0, gcnt=0.
  - freeze=1: go to HOLD.
  - If freeze=1 and a bad window close happen on the same edge, HOLD wins.
- HOLD:
  - Votes are ignored; integ, cdr_control, wcnt, net and gcnt all hold; cdr_locked stays 1.
  - freeze=0: return to LOCKED and resume mid-window.
- freeze is ignored in ACQUIRE and IDLE.
- Reset or enable drop mid-window discards the partial window.

Test Plan:
- Reset with enable=1 and vco_ready=1.
  -> During reset: cdr_control=128, cdr_locked=0, loop_state=0.
  -> First edge after release: loop_state=1.
- ACQUIRE, one early vote -> cdr_control=136 (128+0+8). After 64 consecutive early votes -> 137.
- ACQUIRE, one late vote from reset -> 119 (128-1-8). Continuous early votes -> clamps at 255 once integ >= 7616, and stays at 255; the integrator saturates at 32767 without wrapping.
- Alternating early/late votes, 256 valid samples.
  -> cdr_control alternates 136/120.
  -> cdr_locked=1 and loop_state=2 at the edge of the 256th sample; cdr_control then alternates 132/124.
  -> Then 64 early samples: the window closes with net=64, so the block returns to ACQUIRE with cdr_locked=0.
- In LOCKED, assert freeze for 100 cycles with early votes.
  -> loop_state=3, cdr_control constant.
  -> On release: loop_state=2, and the window counter continues from its frozen value.
- Drop vco_ready (or pulse rst_n) mid-window in LOCKED.
  -> cdr_control=128, cdr_locked=0, loop_state=0.
  -> On recovery: ACQUIRE, and a fresh 4-window lock count is required.
